// File: rtl/bin_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one conversion in flight; done pulses BIN_W+1 cycles after accept.
// Optional BIN_BCD_SIGNED_EN: two's-complement input, converts magnitude and reports sign on neg.
module bin_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
`ifdef BIN_BCD_SIGNED_EN
    output logic                  neg,
`endif
    output logic                  ovf
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CW    = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state;
    logic [BIN_W-1:0]   bin_shift;
    logic [BCD_W-1:0]   acc;
    logic               ovf_acc;
    logic [CW-1:0]      count;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   shifted;
    logic [BIN_W-1:0]   load_val;
`ifdef BIN_BCD_SIGNED_EN
    logic               neg_acc;

    // The most negative value negates to itself, which read unsigned is exactly its magnitude.
    assign load_val = bin[BIN_W-1] ? (~bin) + BIN_W'(1) : bin;
`else
    assign load_val = bin;
`endif

    // Per-digit adjust is 4-bit only; no carry crosses digit boundaries.
    always_comb begin
        adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
        shifted = {adj[BCD_W-2:0], bin_shift[BIN_W-1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd       <= '0;
            ovf       <= 1'b0;
            bin_shift <= '0;
            acc       <= '0;
            ovf_acc   <= 1'b0;
            count     <= '0;
`ifdef BIN_BCD_SIGNED_EN
            neg       <= 1'b0;
            neg_acc   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        bin_shift <= load_val;
                        acc       <= '0;
                        ovf_acc   <= 1'b0;
                        count     <= CW'(BIN_W);
                        state     <= SHIFT;
                        ready     <= 1'b0;
                        busy      <= 1'b1;
`ifdef BIN_BCD_SIGNED_EN
                        neg_acc   <= bin[BIN_W-1];
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    acc       <= shifted;
                    bin_shift <= {bin_shift[BIN_W-2:0], 1'b0};
                    ovf_acc   <= ovf_acc | adj[BCD_W-1];
                    count     <= count - CW'(1);
                    // Final shift: publish result directly so outputs never show partial values.
                    if (count == CW'(1)) begin
                        bcd   <= shifted;
                        ovf   <= ovf_acc | adj[BCD_W-1];
                        done  <= 1'b1;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
`ifdef BIN_BCD_SIGNED_EN
                        neg   <= neg_acc;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
